// File: rtl/mdu_exec_pkg.sv
// Shared mult/div opcode encoding and latency defaults for the execute-stage
// MDU and the hazard unit.
package mdu_exec_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MD_MUL_LAT = 5;
  localparam int MD_DIV_LAT = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    case (op)
      MD_DIV, MD_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_exec_md_compute.sv
// Combinational 64-bit product / quotient / remainder generator; the result is
// returned already split into HI and LO.
module mdu_exec_md_compute
  import mdu_exec_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic        sgn_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] prod_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Signed ops divide magnitudes and then restore signs, which also yields
  // 0x80000000 rem 0 for -2^31 / -1 without a special case.
  always_comb begin
    sgn_s    = (op == MD_MULT) || (op == MD_DIV);
    a_ext_s  = sgn_s ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext_s  = sgn_s ? {{32{b[31]}}, b} : {32'd0, b};
    prod_s   = a_ext_s * b_ext_s;
    a_mag_s  = (sgn_s && a[31]) ? (32'd0 - a) : a;
    b_mag_s  = (sgn_s && b[31]) ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    if (div_zero) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end else begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
    end
    q_s = (sgn_s && (a[31] ^ b[31])) ? (32'd0 - q_mag_s) : q_mag_s;
    r_s = (sgn_s && a[31]) ? (32'd0 - r_mag_s) : r_mag_s;
    case (op)
      MD_MULT, MD_MULTU: begin
        hi = prod_s[63:32];
        lo = prod_s[31:0];
      end
      MD_DIV, MD_DIVU: begin
        hi = r_s;
        lo = q_s;
      end
      default: begin
        hi = 32'd0;
        lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_exec.sv
// Execute-stage multiply/divide unit: owns HI/LO, models fixed mult/div
// latency, and provides the busy flag and MFHI/MFLO read data.
module mdu_exec
  import mdu_exec_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT,
  parameter int DIV_LAT = MD_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_i,
  input  logic [31:0] rs_value_i,
  input  logic [31:0] rt_value_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] rd_data_o
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic             start_s;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      hi_tmp_r;
  logic [31:0]      lo_tmp_r;
  logic             commit_en_r;
  logic [31:0]      comp_hi_s;
  logic [31:0]      comp_lo_s;
  logic             div_zero_s;

  mdu_exec_md_compute u_compute (
    .op       (md_op_i),
    .a        (rs_value_i),
    .b        (rt_value_i),
    .hi       (comp_hi_s),
    .lo       (comp_lo_s),
    .div_zero (div_zero_s)
  );

  assign start_s = is_start_op(md_op_i);
  assign busy_o  = busy_r | start_s;
  assign hi_o    = hi_r;
  assign lo_o    = lo_r;

  // Issue, countdown, commit of the pending result, and MTHI/MTLO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r      <= 1'b0;
      cnt_r       <= '0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      hi_tmp_r    <= 32'd0;
      lo_tmp_r    <= 32'd0;
      commit_en_r <= 1'b0;
    end else if (busy_r) begin
      if (cnt_r == CNT_W'(1)) begin
        busy_r <= 1'b0;
        cnt_r  <= '0;
        if (commit_en_r) begin
          hi_r <= hi_tmp_r;
          lo_r <= lo_tmp_r;
        end
      end else begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end else if (start_s) begin
      busy_r      <= 1'b1;
      cnt_r       <= is_div_op(md_op_i) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      hi_tmp_r    <= comp_hi_s;
      lo_tmp_r    <= comp_lo_s;
      // A divide by zero still occupies the unit but leaves HI/LO untouched.
      commit_en_r <= ~(is_div_op(md_op_i) & div_zero_s);
    end else begin
      case (md_op_i)
        MD_MTHI: hi_r <= rs_value_i;
        MD_MTLO: lo_r <= rs_value_i;
        default: ;
      endcase
    end
  end

  // MFHI/MFLO read path into the E-stage result mux.
  always_comb begin
    case (md_op_i)
      MD_MFHI: rd_data_o = hi_r;
      MD_MFLO: rd_data_o = lo_r;
      default: rd_data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_exec.sv
// Directed test-plan steps followed by random op sequences, all checked
// against a cycle-indexed behavioural model of HI/LO and the busy window.
module tb_mdu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] rd_data_o;

  int compared   = 0;
  int mismatched = 0;

  // Model state: architectural HI/LO plus one pending result with the cycle
  // number of its last busy cycle.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          pend, p_commit;
  int          done_c, cyc_n;

  mdu_exec dut (
    .clk        (clk),
    .reset      (reset),
    .md_op_i    (md_op),
    .rs_value_i (rs_value),
    .rt_value_i (rt_value),
    .busy_o     (busy_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .rd_data_o  (rd_data_o)
  );

  always #5 clk = ~clk;

  function automatic bit m_start(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic bit m_div(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4);
  endfunction

  // Reference arithmetic in plain 64-bit integer math; returns {HI, LO}.
  function automatic logic [63:0] m_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    longint unsigned up;
    logic [31:0] uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1: begin sp = sa * sb; return sp; end
      4'd2: begin up = longint'(a) * longint'(b); return up; end
      4'd3: begin
        if (b == 32'd0) return 64'd0;
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return 64'd0;
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%08h expected=%08h cycle=%0d", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock cycle: drive, check combinational/visible outputs, advance model.
  task automatic cyc(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic rst);
    logic [31:0] exp_rd;
    logic [63:0] res;
    md_op    = op;
    rs_value = rs;
    rt_value = rt;
    reset    = rst;
    #2;
    exp_rd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    chk("busy", {31'd0, busy_o}, {31'd0, pend || m_start(op)});
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
    chk("rd_data", rd_data_o, exp_rd);
    if (rst) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      pend = 1'b0;
    end else if (pend) begin
      if (cyc_n == done_c) begin
        if (p_commit) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
        pend = 1'b0;
      end
    end else if (m_start(op)) begin
      res      = m_result(op, rs, rt);
      p_hi     = res[63:32];
      p_lo     = res[31:0];
      p_commit = !(m_div(op) && rt == 32'd0);
      pend     = 1'b1;
      done_c   = cyc_n + (m_div(op) ? 10 : 5);
    end else if (op == 4'd7) begin
      m_hi = rs;
    end else if (op == 4'd8) begin
      m_lo = rs;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] r_op;
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
    pend = 1'b0; p_commit = 1'b0; done_c = 0; cyc_n = 0;
    reset = 1'b1; md_op = 4'd0; rs_value = 32'd0; rt_value = 32'd0;
    @(posedge clk); #1;
    cyc(4'd0, 32'd0, 32'd0, 1'b1);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);

    cyc(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(5);
    chk("plan_mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("plan_mult_lo", lo_o, 32'hFFFF_FFFE);

    cyc(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(5);
    chk("plan_multu_hi", hi_o, 32'h0000_0001);
    chk("plan_multu_lo", lo_o, 32'hFFFF_FFFE);

    cyc(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(10);
    chk("plan_div_lo", lo_o, 32'hFFFF_FFFD);
    chk("plan_div_hi", hi_o, 32'hFFFF_FFFF);

    cyc(4'd7, 32'h11, 32'd0, 1'b0);
    cyc(4'd8, 32'h22, 32'd0, 1'b0);
    cyc(4'd4, 32'd7, 32'd0, 1'b0);
    idle(10);
    chk("plan_div0_hi", hi_o, 32'h11);
    chk("plan_div0_lo", lo_o, 32'h22);

    cyc(4'd1, 32'd3, 32'd4, 1'b0);
    cyc(4'd0, 32'd0, 32'd0, 1'b0);
    cyc(4'd8, 32'h55, 32'd0, 1'b0);
    cyc(4'd1, 32'd5, 32'd6, 1'b0);
    idle(2);
    chk("plan_drop_hi", hi_o, 32'd0);
    chk("plan_drop_lo", lo_o, 32'h0000_000C);

    cyc(4'd3, 32'd100, 32'd7, 1'b0);
    idle(3);
    cyc(4'd0, 32'd0, 32'd0, 1'b1);
    md_op = 4'd6;
    #1;
    chk("plan_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("plan_rst_rd", rd_data_o, 32'd0);
    cyc(4'd6, 32'd0, 32'd0, 1'b0);

    cyc(4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(5);
    cyc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(10);
    chk("ovf_div_lo", lo_o, 32'h8000_0000);
    chk("ovf_div_hi", hi_o, 32'd0);

    for (int i = 0; i < 600; i++) begin
      r_op = 4'($urandom_range(0, 15));
      cyc(r_op, rand_val(), rand_val(), $urandom_range(0, 60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
